pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall, flush and forwarding controller for the 5-stage pipeline.
- Drives the IF PC-mux select, the IF/ID hold, the ID/EXE bubble and the ID-stage operand-forwarding selects.
- Sequences multi-cycle MDU (mult/div) operations with an internal busy counter.
- Sits beside the ID stage and observes destination info from the EXE, MEM and WB pipeline registers.

Parameters:
- MDU_LAT, 32, cycles a div/mult occupies EXE (including issue cycle); must be ≥2.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_redirect  in  1  ID resolved a taken branch or jump (target on id_pc)
- id_mdu_op  in  1  ID holds div/divu/mult/multu
- exe_wen  in  1  EXE instruction writes RF
- exe_waddr  in  5  EXE destination register
- exe_is_load  in  1  EXE instruction is a load
- mem_wen  in  1  MEM instruction writes RF
- mem_waddr  in  5  MEM destination register
- wb_wen  in  1  WB instruction writes RF
- wb_waddr  in  5  WB destination register
- if_pc_sel  out  2  IF PC-mux select: 00 PC+4, 01 id_pc, 1x hold now_pc
- ifid_hold  out  1  IF/ID register keeps its value
- idexe_bubble  out  1  ID/EXE register loads a NOP
- fwd_rs_sel  out  2  rs source: 00 RF, 01 EXE Z, 10 MEM data, 11 WB data
- fwd_rt_sel  out  2  rt source, same encoding as fwd_rs_sel
- mdu_busy  out  1  MDU occupying EXE

Behaviour:
- FSM states: RUN, MDU_WAIT. Reset → RUN, counter 0.
- While rst_n is low: if_pc_sel=10, ifid_hold=1, idexe_bubble=1, fwd_*=00, mdu_busy=0.
- Reset asserted mid-MDU: state returns to RUN and the counter is cleared immediately; no stall persists after reset release.
- Forwarding (combinational, per operand, operand address X):
  - X==0 or operand not used → 00.
  - else exe_wen && exe_waddr==X && !exe_is_load → 01.
  - else mem_wen && mem_waddr==X → 10.
  - else wb_wen && wb_waddr==X → 11.
  - else 00.
  - Youngest stage wins.
- load_use = exe_is_load && exe_wen && exe_waddr≠0 && (rs or rt of ID matches exe_waddr with its use bit set).
- Priority each cycle: MDU_WAIT stall > load_use stall > redirect > normal.
- MDU_WAIT:
  - Outputs: if_pc_sel=10, ifid_hold=1, idexe_bubble=1, mdu_busy=1.
  - Counter decrements each cycle.
  - At counter==1 the state returns to RUN next cycle, so the stall is exactly MDU_LAT−1 cycles after the issue cycle.
- RUN, id_mdu_op and no load_use:
  - The instruction issues normally this cycle.
  - Next cycle: state MDU_WAIT, counter=MDU_LAT−1.
- RUN, load_use:
  - One-cycle stall: if_pc_sel=10, ifid_hold=1, idexe_bubble=1.
  - id_redirect and id_mdu_op are ignored this cycle; they re-evaluate next cycle with forward 10.
- RUN, id_redirect, no stall:
  - if_pc_sel=01, ifid_hold=0, idexe_bubble=0.
  - No flush: delay slot semantics.
- RUN, otherwise: if_pc_sel=00, hold=0, bubble=0.
- id_redirect and id_mdu_op together never occur (decoder exclusive); if they do, the redirect is taken and the MDU issue still starts the MDU_WAIT sequence.
- All outputs except the state and counter are combinational from state and inputs, with zero latency, because the PC mux needs them in the same cycle.

Decomposition:
- Shared package pipe_pkg:
  - PC-select encodings: PCSEL_ADD=2'b00, PCSEL_ID=2'b01, PCSEL_HOLD=2'b10.
  - Forward encodings: FWD_RF, FWD_EXE, FWD_MEM, FWD_WB.
  - State enum.
- One natural sub-module: pipe_fwd_sel, the per-operand priority comparator, instantiated twice (rs, rt).

Test Plan:
- Reset: rst_n=0 with arbitrary inputs → if_pc_sel=10, ifid_hold=1, idexe_bubble=1; release with quiet inputs → 00/0/0.
- Forwarding: id_rs=5, id_use_rs=1.
  - exe_wen=1, exe_waddr=5 → fwd_rs_sel=01.
  - Drop exe_wen, set mem_waddr=5 → 10.
  - Only wb_waddr=5 → 11.
  - id_rs=0 with all matching → 00.
- Load-use: exe_is_load=1, exe_waddr=8, id_rt=8, id_use_rt=1 → one cycle of hold/bubble with if_pc_sel=10; next cycle (load in MEM) → fwd_rt_sel=10, no stall.
- Branch: id_redirect=1, no hazards → if_pc_sel=01, no hold.
- Load-use + redirect: id_redirect=1 with load_use → stall cycle with if_pc_sel=10, then 01 the following cycle.
- MDU: id_mdu_op=1 with MDU_LAT=32 → issue cycle normal, then exactly 31 cycles of mdu_busy=1 with hold/bubble, then RUN.
- MDU reset abort: assert rst_n=0 at stall cycle 10 → after release, mdu_busy=0 and if_pc_sel=00.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: PC-mux selects,
// operand-forward selects and the controller state.
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] PCSEL_ADD  = 2'b00;
    localparam logic [1:0] PCSEL_ID   = 2'b01;
    localparam logic [1:0] PCSEL_HOLD = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding priority comparator; the youngest producing stage wins.
module pipe_fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] addr,
    input  logic       use_op,
    input  logic       exe_wen,
    input  logic [4:0] exe_waddr,
    input  logic       exe_is_load,
    input  logic       mem_wen,
    input  logic [4:0] mem_waddr,
    input  logic       wb_wen,
    input  logic [4:0] wb_waddr,
    output logic [1:0] sel
);

    // A load in EXE has no result yet; load-use stalling covers that case.
    always_comb begin
        sel = FWD_RF;
        if (use_op && (addr != 5'd0)) begin
            if (exe_wen && (exe_waddr == addr) && !exe_is_load) begin
                sel = FWD_EXE;
            end else if (mem_wen && (mem_waddr == addr)) begin
                sel = FWD_MEM;
            end else if (wb_wen && (wb_waddr == addr)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, redirect and forwarding control for the 5-stage pipeline, including
// sequencing of multi-cycle MDU operations occupying EXE.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MDU_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_redirect,
    input  logic       id_mdu_op,
    input  logic       exe_wen,
    input  logic [4:0] exe_waddr,
    input  logic       exe_is_load,
    input  logic       mem_wen,
    input  logic [4:0] mem_waddr,
    input  logic       wb_wen,
    input  logic [4:0] wb_waddr,
    output logic [1:0] if_pc_sel,
    output logic       ifid_hold,
    output logic       idexe_bubble,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       mdu_busy
);

    hz_state_e        state;
    hz_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_use;
    logic [1:0]       rs_sel;
    logic [1:0]       rt_sel;

    pipe_fwd_sel u_fwd_rs (
        .addr        (id_rs),
        .use_op      (id_use_rs),
        .exe_wen     (exe_wen),
        .exe_waddr   (exe_waddr),
        .exe_is_load (exe_is_load),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .sel         (rs_sel)
    );

    pipe_fwd_sel u_fwd_rt (
        .addr        (id_rt),
        .use_op      (id_use_rt),
        .exe_wen     (exe_wen),
        .exe_waddr   (exe_waddr),
        .exe_is_load (exe_is_load),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .sel         (rt_sel)
    );

    assign load_use = exe_is_load && exe_wen && (exe_waddr != 5'd0) &&
                      ((id_use_rs && (id_rs == exe_waddr)) ||
                       (id_use_rt && (id_rt == exe_waddr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: an MDU op issues in RUN only when not held by a load-use stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (!load_use && id_mdu_op) begin
                    state_nxt = ST_MDU_WAIT;
                    cnt_nxt   = CNT_W'(MDU_LAT - 1);
                end
            end
            ST_MDU_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Zero-latency controls: the PC mux consumes these in the same cycle.
    always_comb begin
        if_pc_sel    = PCSEL_ADD;
        ifid_hold    = 1'b0;
        idexe_bubble = 1'b0;
        mdu_busy     = 1'b0;
        fwd_rs_sel   = rs_sel;
        fwd_rt_sel   = rt_sel;
        if (!rst_n) begin
            if_pc_sel    = PCSEL_HOLD;
            ifid_hold    = 1'b1;
            idexe_bubble = 1'b1;
            fwd_rs_sel   = FWD_RF;
            fwd_rt_sel   = FWD_RF;
        end else if (state == ST_MDU_WAIT) begin
            if_pc_sel    = PCSEL_HOLD;
            ifid_hold    = 1'b1;
            idexe_bubble = 1'b1;
            mdu_busy     = 1'b1;
        end else if (load_use) begin
            if_pc_sel    = PCSEL_HOLD;
            ifid_hold    = 1'b1;
            idexe_bubble = 1'b1;
        end else if (id_redirect) begin
            if_pc_sel    = PCSEL_ID;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, each
// cycle checked against a behavioural model of stalls, redirects and forwarding.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MDU_LAT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt, id_redirect, id_mdu_op;
    logic       exe_wen, exe_is_load, mem_wen, wb_wen;
    logic [4:0] exe_waddr, mem_waddr, wb_waddr;
    logic [1:0] if_pc_sel, fwd_rs_sel, fwd_rt_sel;
    logic       ifid_hold, idexe_bubble, mdu_busy;

    int checks   = 0;
    int failures = 0;
    int stall_left = 0;   // model: remaining MDU stall cycles
    int busy_run;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_redirect  (id_redirect),
        .id_mdu_op    (id_mdu_op),
        .exe_wen      (exe_wen),
        .exe_waddr    (exe_waddr),
        .exe_is_load  (exe_is_load),
        .mem_wen      (mem_wen),
        .mem_waddr    (mem_waddr),
        .wb_wen       (wb_wen),
        .wb_waddr     (wb_waddr),
        .if_pc_sel    (if_pc_sel),
        .ifid_hold    (ifid_hold),
        .idexe_bubble (idexe_bubble),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .mdu_busy     (mdu_busy)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Source of an operand: scan producers from youngest to oldest.
    function automatic logic [1:0] model_fwd(input logic [4:0] a, input logic u);
        logic       wen [3];
        logic [4:0] wad [3];
        if (!u || a == 5'd0) return 2'd0;
        wen[0] = exe_wen && !exe_is_load; wad[0] = exe_waddr;
        wen[1] = mem_wen;                 wad[1] = mem_waddr;
        wen[2] = wb_wen;                  wad[2] = wb_waddr;
        for (int s = 0; s < 3; s++)
            if (wen[s] && wad[s] == a) return 2'(s + 1);
        return 2'd0;
    endfunction

    function automatic bit model_load_use();
        if (!(exe_is_load && exe_wen) || exe_waddr == 5'd0) return 1'b0;
        return (id_use_rs && id_rs == exe_waddr) || (id_use_rt && id_rt == exe_waddr);
    endfunction

    // Called at a negedge with inputs applied; checks, then advances one cycle.
    task automatic tick();
        logic [1:0] e_pc, e_rs, e_rt;
        logic       e_stall, e_busy;
        bit         lu;
        #1;
        lu     = model_load_use();
        e_rs   = model_fwd(id_rs, id_use_rs);
        e_rt   = model_fwd(id_rt, id_use_rt);
        e_busy = 1'b0;
        if (!rst_n) begin
            stall_left = 0;
            e_pc = 2'b10; e_stall = 1'b1; e_rs = 2'b00; e_rt = 2'b00;
        end else if (stall_left > 0) begin
            e_pc = 2'b10; e_stall = 1'b1; e_busy = 1'b1;
        end else if (lu) begin
            e_pc = 2'b10; e_stall = 1'b1;
        end else if (id_redirect) begin
            e_pc = 2'b01; e_stall = 1'b0;
        end else begin
            e_pc = 2'b00; e_stall = 1'b0;
        end
        chk("if_pc_sel",    if_pc_sel,            e_pc);
        chk("ifid_hold",    {1'b0, ifid_hold},    {1'b0, e_stall});
        chk("idexe_bubble", {1'b0, idexe_bubble}, {1'b0, e_stall});
        chk("fwd_rs_sel",   fwd_rs_sel,           e_rs);
        chk("fwd_rt_sel",   fwd_rt_sel,           e_rt);
        chk("mdu_busy",     {1'b0, mdu_busy},     {1'b0, e_busy});
        @(posedge clk);
        if (!rst_n) stall_left = 0;
        else if (stall_left > 0) stall_left--;
        else if (!lu && id_mdu_op) stall_left = MDU_LAT - 1;
        @(negedge clk);
    endtask

    task automatic quiet();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_redirect = 1'b0; id_mdu_op = 1'b0;
        exe_wen = 1'b0; exe_waddr = 5'd0; exe_is_load = 1'b0;
        mem_wen = 1'b0; mem_waddr = 5'd0; wb_wen = 1'b0; wb_waddr = 5'd0;
    endtask

    task automatic randomize_inputs(input int unsigned areg);
        id_rs = 5'($urandom_range(areg)); id_rt = 5'($urandom_range(areg));
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        exe_wen = 1'($urandom); exe_waddr = 5'($urandom_range(areg));
        exe_is_load = ($urandom_range(3) == 0);
        mem_wen = 1'($urandom); mem_waddr = 5'($urandom_range(areg));
        wb_wen = 1'($urandom); wb_waddr = 5'($urandom_range(areg));
        id_redirect = ($urandom_range(4) == 0);
        id_mdu_op = ($urandom_range(30) == 0);
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset with arbitrary inputs, then release quietly.
        randomize_inputs(31);
        tick();
        quiet(); tick();
        rst_n = 1'b1; tick();
        chk("run_after_reset", if_pc_sel, 2'b00);

        // Forwarding priority on rs.
        id_rs = 5'd5; id_use_rs = 1'b1;
        exe_wen = 1'b1; exe_waddr = 5'd5; mem_wen = 1'b1; wb_wen = 1'b1;
        tick();
        exe_wen = 1'b0; mem_waddr = 5'd5; tick();
        mem_waddr = 5'd0; wb_waddr = 5'd5; tick();
        chk("fwd_wb_only", fwd_rs_sel, 2'b11);
        exe_wen = 1'b1; mem_waddr = 5'd5; id_rs = 5'd0; exe_waddr = 5'd0; wb_waddr = 5'd0;
        tick();

        // Load-use stall, then the load is in MEM.
        quiet();
        exe_wen = 1'b1; exe_is_load = 1'b1; exe_waddr = 5'd8; id_rt = 5'd8; id_use_rt = 1'b1;
        tick();
        quiet(); id_rt = 5'd8; id_use_rt = 1'b1; mem_wen = 1'b1; mem_waddr = 5'd8;
        tick();

        // Branch with no hazard.
        quiet(); id_redirect = 1'b1; tick();

        // Load-use with redirect: stall first, redirect next cycle.
        exe_wen = 1'b1; exe_is_load = 1'b1; exe_waddr = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        tick();
        quiet(); id_redirect = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1; mem_wen = 1'b1; mem_waddr = 5'd9;
        tick();
        chk("redirect_after_stall", if_pc_sel, 2'b01);

        // Full MDU sequence: count stall cycles independently.
        quiet(); id_mdu_op = 1'b1; tick();
        id_mdu_op = 1'b0;
        busy_run = 0;
        for (int i = 0; i < MDU_LAT + 3; i++) begin
            if (mdu_busy === 1'b1) busy_run++;
            tick();
        end
        chk("mdu_stall_len", 2'(busy_run == int'(MDU_LAT - 1)), 2'd1);

        // MDU aborted by reset at stall cycle 10.
        id_mdu_op = 1'b1; tick();
        id_mdu_op = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        chk("abort_busy", {1'b0, mdu_busy}, 2'b00);
        chk("abort_pcsel", if_pc_sel, 2'b00);

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            randomize_inputs(3);
            rst_n = ($urandom_range(150) != 0);
            tick();
        end
        rst_n = 1'b1;
        quiet();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
